// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// ----------------
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// Four BCD digits plus the blanking / decimal-point / blink controls are
// captured once per scan frame, so a frame is never torn by inputs that change
// while it is being shown. Every output is registered, and each digit slot
// starts with one dead cycle (all anodes off) to suppress ghosting.
//
// Parameters
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   BLINK_DIV    digit slots per blink half-period (>= 1)
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   digit3..0   BCD digits, digit3 leftmost, digit0 rightmost
//   blank_lead  enable leading-zero blanking
//   dp_mask     bit i lights the decimal point of digit i
//   blink_en    bit i makes digit i blink
//   an          anode enables, active-low, bit i = digit i
//   seg         cathodes, active-low, {g,f,e,d,c,b,a}
//   dp          decimal-point cathode, active-low
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic       blank_lead,
  input  logic [3:0] dp_mask,
  input  logic [3:0] blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Scan timing
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  // Frame holding registers
  logic [3:0][3:0] hdig_q, hdig_d;
  logic            hbl_q, hbl_d;
  logic [3:0]      hdp_q, hdp_d;
  logic [3:0]      hblk_q, hblk_d;

  // Registered outputs
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  logic       tick;
  logic       frame_latch;
  logic       blink_wrap;
  logic [3:0] lead_zero;
  logic [3:0] digit_blank;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;  // invalid BCD shows a dash
    endcase
  endfunction

  assign tick        = (presc_q == PRESC_LAST);
  assign frame_latch = tick && (idx_q == 2'd3);
  assign blink_wrap  = tick && (bcnt_q == BLINK_LAST);

  // A digit is a leading zero only if it and every digit to its left are 0.
  // Any non-zero value (including invalid >9) stops the chain. Digit 0 is
  // always shown.
  assign lead_zero[3] = hbl_q && (hdig_q[3] == 4'd0);
  assign lead_zero[2] = lead_zero[3] && (hdig_q[2] == 4'd0);
  assign lead_zero[1] = lead_zero[2] && (hdig_q[1] == 4'd0);
  assign lead_zero[0] = 1'b0;

  assign digit_blank = lead_zero | (hblk_q & {4{phase_q}});

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;

    bcnt_d  = bcnt_q;
    if (tick) bcnt_d = blink_wrap ? '0 : bcnt_q + 1'b1;
    phase_d = phase_q ^ blink_wrap;

    hdig_d = hdig_q;
    hbl_d  = hbl_q;
    hdp_d  = hdp_q;
    hblk_d = hblk_q;
    if (frame_latch) begin
      hdig_d = {digit3, digit2, digit1, digit0};
      hbl_d  = blank_lead;
      hdp_d  = dp_mask;
      hblk_d = blink_en;
    end

    // Default is the dark pattern: used for the dead cycle at each tick and
    // for blanked slots. Otherwise show the slot selected by the current
    // index; the tick edge has already moved the index to the new slot.
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!tick && !digit_blank[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = bcd_to_seg(hdig_q[idx_q]);
      dp_d  = ~hdp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      hdig_q  <= '0;
      hbl_q   <= 1'b0;
      hdp_q   <= 4'd0;
      hblk_q  <= 4'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      hdig_q  <= hdig_d;
      hbl_q   <= hbl_d;
      hdp_q   <= hdp_d;
      hblk_q  <= hblk_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with REFRESH_DIV=4, BLINK_DIV=8.
module tb_seg7_scan_driver;

  localparam int R = 4;
  localparam int B = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
  logic       bl = 1'b0;
  logic [3:0] dpm = 4'd0, ben = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst),
    .digit3(d3), .digit2(d2), .digit1(d1), .digit0(d0),
    .blank_lead(bl), .dp_mask(dpm), .blink_en(ben),
    .an(an), .seg(seg), .dp(dp)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Works from the number of clock edges since reset release: edge k falls in
  // slot (k-1)/R, the last edge of each slot is the dead cycle, the blink
  // phase is (slots elapsed / B) mod 2, and the frame copy is taken on the
  // dead edge that closes slot index 3.
  logic [6:0] seg_tab [16];
  int         k_edges;
  logic [3:0] m_dig [4];
  logic       m_bl;
  logic [3:0] m_dpm, m_ben;
  logic [11:0] exp_q[$];

  task automatic model_edge();
    logic [11:0] e;
    int p, n, i;
    bit blank, allz;
    logic [3:0] an_e;
    e = 12'hFFF;
    if (rst) begin
      k_edges = 0;
      for (int j = 0; j < 4; j++) m_dig[j] = 4'd0;
      m_bl = 1'b0; m_dpm = 4'd0; m_ben = 4'd0;
    end else begin
      k_edges++;
      p = (k_edges - 1) % R;
      n = (k_edges - 1) / R;
      if (p == R - 1) begin
        if (n % 4 == 3) begin
          m_dig[3] = d3; m_dig[2] = d2; m_dig[1] = d1; m_dig[0] = d0;
          m_bl = bl; m_dpm = dpm; m_ben = ben;
        end
      end else begin
        i = n % 4;
        blank = (((n / B) % 2) == 1) && m_ben[i];
        if (m_bl && i > 0) begin
          allz = 1'b1;
          for (int j = i; j < 4; j++) if (m_dig[j] != 4'd0) allz = 1'b0;
          if (allz) blank = 1'b1;
        end
        if (!blank) begin
          an_e = 4'b1111;
          an_e[i] = 1'b0;
          e = {an_e, seg_tab[m_dig[i]], ~m_dpm[i]};
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [11:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("cycle", {an, seg, dp}, e);
  endtask

  task automatic steps(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic wait_an(input logic [3:0] target, input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      step();
      if (an === target) found = 1'b1;
    end
    check(name, {11'd0, found}, 12'd1);
  endtask

  task automatic set_inputs(input logic [15:0] digs, input logic b, input logic [3:0] dm,
                            input logic [3:0] be);
    {d3, d2, d1, d0} = digs;
    bl = b; dpm = dm; ben = be;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [15:0] digs;   // {d3,d2,d1,d0}
    logic        bl;
    logic [3:0]  dpm;
    logic [3:0]  lit_e;  // which digits are visible
    logic [27:0] segs_e; // {seg3,seg2,seg1,seg0}
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [6:0] obs_seg [4];
    logic       obs_dp [4];
    logic [3:0] seen;
    logic [27:0] se;
    bit lit;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    vecs[0] = '{16'h0042, 1'b1, 4'b0000, 4'b0011, {7'h7F, 7'h7F, 7'h19, 7'h24}};
    vecs[1] = '{16'h0042, 1'b0, 4'b0000, 4'b1111, {7'h40, 7'h40, 7'h19, 7'h24}};
    vecs[2] = '{16'h0000, 1'b1, 4'b0000, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{16'h0A05, 1'b1, 4'b0000, 4'b0111, {7'h7F, 7'h3F, 7'h40, 7'h12}};
    vecs[4] = '{16'h9876, 1'b1, 4'b1010, 4'b1111, {7'h10, 7'h00, 7'h78, 7'h02}};
    vecs[5] = '{16'h1300, 1'b1, 4'b0001, 4'b1111, {7'h79, 7'h30, 7'h40, 7'h40}};
    vecs[6] = '{16'h00F0, 1'b1, 4'b0100, 4'b0011, {7'h7F, 7'h7F, 7'h3F, 7'h40}};

    // ---- reset held for 3 cycles, then the first slots ----
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("reset_hold", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
    end
    rst = 1'b0;
    step();
    check("first_after_reset", {an, seg, dp}, {4'b1110, 7'h40, 1'b1});
    steps(R - 1);
    check("first_dead", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
    step();
    check("slot1_an", {8'd0, an}, {8'd0, 4'b1101});
    steps(R - 1);
    step();
    check("slot2_an", {8'd0, an}, {8'd0, 4'b1011});
    steps(R - 1);
    step();
    check("slot3_an", {8'd0, an}, {8'd0, 4'b0111});

    // ---- table-driven static patterns ----
    foreach (vecs[v]) begin
      set_inputs(vecs[v].digs, vecs[v].bl, vecs[v].dpm, 4'b0000);
      steps(8 * R);
      seen = 4'b0000;
      for (int c = 0; c < 4 * R; c++) begin
        step();
        for (int i = 0; i < 4; i++) begin
          if (an === ~(4'b0001 << i)) begin
            seen[i] = 1'b1;
            obs_seg[i] = seg;
            obs_dp[i] = dp;
          end
        end
      end
      se = vecs[v].segs_e;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("vec%0d_lit%0d", v, i), {11'd0, seen[i]}, {11'd0, vecs[v].lit_e[i]});
        if (vecs[v].lit_e[i] && seen[i]) begin
          check($sformatf("vec%0d_seg%0d", v, i), {5'd0, obs_seg[i]}, {5'd0, se[7*i +: 7]});
          check($sformatf("vec%0d_dp%0d", v, i), {11'd0, obs_dp[i]}, {11'd0, ~vecs[v].dpm[i]});
        end
      end
    end

    // ---- mid-frame change: value stays frozen until the next frame ----
    set_inputs(16'h0002, 1'b0, 4'b0000, 4'b0000);
    steps(8 * R);
    wait_an(4'b0111, 4 * R + 4, "wait_slot3");
    wait_an(4'b1110, 4 * R + 4, "wait_slot0");
    d0 = 4'd7;
    step();
    check("midframe_hold_a", {an, seg, dp}, {4'b1110, 7'h24, 1'b1});
    step();
    check("midframe_hold_b", {an, seg, dp}, {4'b1110, 7'h24, 1'b1});
    wait_an(4'b1101, 4 * R + 4, "wait_slot1");
    wait_an(4'b1110, 4 * R + 4, "wait_slot0_next");
    check("midframe_new", {an, seg, dp}, {4'b1110, 7'h78, 1'b1});

    // ---- blink and decimal point from a fresh reset ----
    rst = 1'b1;
    set_inputs(16'h0000, 1'b0, 4'b0010, 4'b0001);
    steps(2);
    rst = 1'b0;
    for (int s = 0; s < 32; s++) begin
      step();
      if (s % 4 == 0) begin
        lit = ((s / B) % 2) == 0;
        check($sformatf("blink_s%0d", s), {8'd0, an}, {8'd0, lit ? 4'b1110 : 4'b1111});
      end
      if (s % 4 == 1 && s >= 5)
        check($sformatf("dp_s%0d", s), {8'd0, an, dp}, {8'd0, 4'b1101, 1'b0});
      steps(R - 2);
      step();
      check("dead_dp", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
    end

    // ---- reset mid-operation ----
    set_inputs(16'h0005, 1'b0, 4'b0000, 4'b0000);
    steps(8 * R);
    wait_an(4'b1011, 4 * R + 4, "wait_slot2");
    rst = 1'b1;
    step();
    check("midrst_values", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
    rst = 1'b0;
    step();
    check("midrst_restart", {an, seg, dp}, {4'b1110, 7'h40, 1'b1});
    steps(4 * R);
    check("midrst_latched", {an, seg, dp}, {4'b1110, 7'h12, 1'b1});

    // ---- randomized stimulus against the model ----
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        d3 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        d2 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        d1 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        d0 = 4'($urandom_range(0, 15));
        bl = 1'($urandom_range(0, 1));
        dpm = 4'($urandom_range(0, 15));
        ben = 4'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
